// File: rtl/affine_ctrl_pkg.sv
// Shared types, widths and config register map for the affine loop controller.
package affine_ctrl_pkg;

    localparam int unsigned CW   = 16;
    localparam int unsigned NDIM = 3;
    localparam int unsigned CntW = CW + 1;

    typedef logic [NDIM-1:0][CW-1:0] ctrl_vec_t;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRun
    } state_t;

    localparam logic [2:0] CfgAddrExt0  = 3'd0;
    localparam logic [2:0] CfgAddrExt1  = 3'd1;
    localparam logic [2:0] CfgAddrExt2  = 3'd2;
    localparam logic [2:0] CfgAddrDelay = 3'd3;
    localparam logic [2:0] CfgAddrIi    = 3'd4;
    localparam logic [2:0] CfgAddrGap   = 3'd5;

    // An initiation interval of zero behaves as back-to-back issue.
    function automatic logic [CW-1:0] eff_ii(input logic [CW-1:0] ii);
        return (ii == '0) ? CW'(1) : ii;
    endfunction

endpackage

// File: rtl/affine_idx_counter.sv
// Three-level nested wrap counter holding the index of the next issue.
// cur shows the index that an issue this cycle would carry; inc advances past it.
module affine_idx_counter
    import affine_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic      inc,
    input  ctrl_vec_t extent,
    output ctrl_vec_t cur,
    output logic      last,
    output logic      wrap
);

    ctrl_vec_t       idx_q;
    ctrl_vec_t       idx_d;
    ctrl_vec_t       nxt;
    logic [NDIM-1:0] at_max;
    logic            carry;

    always_comb begin
        cur = clear ? '0 : idx_q;
        for (int i = 0; i < NDIM; i++) begin
            at_max[i] = (cur[i] == extent[i] - CW'(1));
        end
        last = &at_max;
        wrap = at_max[NDIM-1];

        // Innermost level counts every step; a level at its maximum wraps and carries outward.
        nxt   = cur;
        carry = 1'b1;
        for (int i = NDIM - 1; i >= 0; i--) begin
            if (carry) begin
                if (at_max[i]) begin
                    nxt[i] = '0;
                end else begin
                    nxt[i] = cur[i] + CW'(1);
                end
                carry = at_max[i];
            end
        end

        idx_d = inc ? nxt : cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/affine_loop_ctrl.sv
// Issue-side controller for unified-buffer ports: affine start/II/row-gap schedule over a
// 3-deep loop nest. Optional stall support is built when AFFINE_CTRL_STALL_EN is defined.
module affine_loop_ctrl
    import affine_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_addr,
    input  logic [CW-1:0]           cfg_data,
    input  logic                    stall,
    output logic                    valid,
    output logic [NDIM-1:0][CW-1:0] ctrl_vars,
    output logic                    busy,
    output logic                    done
);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fin_q, fin_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    ctrl_vec_t       ctrl_q, ctrl_d;

    ctrl_vec_t       ext_q;
    logic [CW-1:0]   delay_q;
    logic [CW-1:0]   ii_q;
    logic [CW-1:0]   gap_q;

    logic            idx_clear;
    logic            idx_inc;
    ctrl_vec_t       idx_cur;
    logic            idx_last;
    logic            idx_wrap;

    logic            stall_act;
    logic            any_zero;
    logic            fire;
    logic [CntW-1:0] next_gap;

`ifdef AFFINE_CTRL_STALL_EN
    assign stall_act = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_act    = 1'b0;
`endif

    affine_idx_counter u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (idx_clear),
        .inc    (idx_inc),
        .extent (ext_q),
        .cur    (idx_cur),
        .last   (idx_last),
        .wrap   (idx_wrap)
    );

    // Countdown to the issue after the one being made now; cnt == 0 means issue next cycle.
    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NDIM; i++) begin
            any_zero = any_zero | (ext_q[i] == '0);
        end
        next_gap = {1'b0, eff_ii(ii_q)} - CntW'(1);
        if (idx_wrap && !idx_last) begin
            next_gap = next_gap + {1'b0, gap_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ctrl_d    = ctrl_q;
        idx_clear = 1'b0;
        idx_inc   = 1'b0;
        fire      = 1'b0;

        if (flush) begin
            idx_clear = 1'b1;
            fin_d     = 1'b0;
            busy_d    = 1'b1;
            state_d   = StDelay;
            cnt_d     = {1'b0, delay_q} - CntW'(1);
            fire      = (delay_q == '0);
        end else if (stall_act) begin
            // Freeze everything; the pending issue stays latched until stall drops.
            valid_d = valid_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StDelay, StRun: begin
                    if (fin_q) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        fin_d   = 1'b0;
                    end else if (cnt_q == '0) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (fire) begin
            if (any_zero) begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = idx_cur;
                idx_inc = 1'b1;
                cnt_d   = next_gap;
                state_d = StRun;
                busy_d  = 1'b1;
                fin_d   = idx_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctrl_q  <= '0;
            for (int i = 0; i < NDIM; i++) begin
                ext_q[i] <= CW'(1);
            end
            delay_q <= '0;
            ii_q    <= CW'(1);
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
            if (cfg_we && !busy_q) begin
                case (cfg_addr)
                    CfgAddrExt0:  ext_q[0] <= cfg_data;
                    CfgAddrExt1:  ext_q[1] <= cfg_data;
                    CfgAddrExt2:  ext_q[2] <= cfg_data;
                    CfgAddrDelay: delay_q  <= cfg_data;
                    CfgAddrIi:    ii_q     <= cfg_data;
                    CfgAddrGap:   gap_q    <= cfg_data;
                    default: begin
                    end
                endcase
            end
        end
    end

    // During a stall ctrl_vars already presents the pending index; only valid is masked.
    assign valid     = valid_q & ~stall_act;
    assign ctrl_vars = ctrl_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
